// File: rtl/matrix_meta_reader.sv
// matrix_meta_reader: fetches the three metadata words of one matrix block
// from BRAM and returns them decoded as rows, cols and an 8-byte name.
// Optional build macro MATRIX_META_CHECK_EN adds a format check on meta_error.
//
// state  | meaning
// IDLE   | waiting for read_request
// ISSUE0 | matrix_id latched; next edge issues word0 read
// ISSUE1 | word0 read on the bus; next edge issues word1
// ISSUE2 | word1 read on the bus; next edge issues word2
// WAIT   | reads issued, waiting for word2 to come back
// DONE   | read_done pulse, results valid; can accept a new request
module matrix_meta_reader #(
   parameter int BLOCK_SIZE   = 1152,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 14,
   parameter int READ_LATENCY = 1,
   parameter int MAX_DIM      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  read_request,
   output logic                  read_ready,
   input  logic [2:0]            matrix_id,
   output logic                  read_done,
   output logic [7:0]            meta_rows,
   output logic [7:0]            meta_cols,
   output logic [63:0]           meta_name,
   output logic                  meta_valid,
   output logic                  meta_error,
   output logic                  bram_rd_en,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_dout
);

   typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, ISSUE2, WAIT, DONE} state_t;

   state_t                          state;
   logic [ADDR_WIDTH-1:0]           base_addr;
   logic [1:0]                      issue_idx;
   logic [READ_LATENCY-1:0]         pipe_v;
   logic [READ_LATENCY-1:0][1:0]    pipe_idx;
   logic [7:0]                      cap_rows;
   logic [7:0]                      cap_cols;
   logic [31:0]                     cap_word1;
   logic [31:0]                     cap_word2;
   logic                            cap_last;
   logic                            cap_nonzero;
   logic                            fmt_err;

   assign read_ready  = (state == IDLE) || (state == DONE);
   assign cap_nonzero = (cap_rows != 8'd0) && (cap_cols != 8'd0);

`ifdef MATRIX_META_CHECK_EN
   logic [15:0] cap_rsvd;

   // Format check on the captured word set; cleared blocks never flag.
   assign fmt_err = cap_nonzero &&
                    ((int'(cap_rows) > MAX_DIM) || (int'(cap_cols) > MAX_DIM) ||
                     (cap_rsvd != 16'd0));
`else
   localparam int unused_max_dim = MAX_DIM;
   assign fmt_err = 1'b0;
`endif

   // Sequencer: accepts requests, issues three back-to-back reads, publishes results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         base_addr  <= '0;
         issue_idx  <= 2'd0;
         bram_rd_en <= 1'b0;
         bram_addr  <= '0;
         read_done  <= 1'b0;
         meta_rows  <= 8'd0;
         meta_cols  <= 8'd0;
         meta_name  <= 64'd0;
         meta_valid <= 1'b0;
         meta_error <= 1'b0;
      end else begin
         bram_rd_en <= 1'b0;
         read_done  <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (read_request) begin
                  state     <= ISSUE0;
                  base_addr <= ADDR_WIDTH'(32'(matrix_id) * BLOCK_SIZE);
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE0: begin
               bram_rd_en <= 1'b1;
               bram_addr  <= base_addr;
               issue_idx  <= 2'd0;
               state      <= ISSUE1;
            end
            ISSUE1: begin
               bram_rd_en <= 1'b1;
               bram_addr  <= base_addr + ADDR_WIDTH'(1);
               issue_idx  <= 2'd1;
               state      <= ISSUE2;
            end
            ISSUE2: begin
               bram_rd_en <= 1'b1;
               bram_addr  <= base_addr + ADDR_WIDTH'(2);
               issue_idx  <= 2'd2;
               state      <= WAIT;
            end
            WAIT: begin
               if (cap_last) begin
                  state      <= DONE;
                  read_done  <= 1'b1;
                  meta_rows  <= cap_rows;
                  meta_cols  <= cap_cols;
                  meta_name  <= {cap_word1, cap_word2};
                  meta_valid <= cap_nonzero;
                  meta_error <= fmt_err;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Return path: tag each issued read and capture the word once its data lands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe_v    <= '0;
         pipe_idx  <= '0;
         cap_rows  <= 8'd0;
         cap_cols  <= 8'd0;
         cap_word1 <= 32'd0;
         cap_word2 <= 32'd0;
         cap_last  <= 1'b0;
`ifdef MATRIX_META_CHECK_EN
         cap_rsvd  <= 16'd0;
`endif
      end else begin
         pipe_v[0]   <= bram_rd_en;
         pipe_idx[0] <= issue_idx;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
         end
         cap_last <= 1'b0;
         if (pipe_v[READ_LATENCY-1]) begin
            case (pipe_idx[READ_LATENCY-1])
               2'd0: begin
                  cap_rows <= bram_dout[31:24];
                  cap_cols <= bram_dout[23:16];
`ifdef MATRIX_META_CHECK_EN
                  cap_rsvd <= bram_dout[15:0];
`endif
               end
               2'd1: cap_word1 <= bram_dout[31:0];
               default: begin
                  cap_word2 <= bram_dout[31:0];
                  cap_last  <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_matrix_meta_reader.sv
// Bench for matrix_meta_reader: scoreboard of expected BRAM addresses and
// decoded results, plus directed checks and a READ_LATENCY=3 instance.
module tb_matrix_meta_reader;
   localparam int AW = 14;
   localparam int DW = 32;
   localparam int BS = 1152;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, read_request, read_ready, read_done;
   logic [2:0]    matrix_id;
   logic [7:0]    meta_rows, meta_cols;
   logic [63:0]   meta_name;
   logic          meta_valid, meta_error, bram_rd_en;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_dout;

   logic          req3, ready3, done3, valid3, error3, rd_en3;
   logic [2:0]    id3;
   logic [7:0]    rows3, cols3;
   logic [63:0]   name3;
   logic [AW-1:0] addr3;
   logic [DW-1:0] dout3, p1_3, p2_3;

   logic [DW-1:0] mem [0:16383];
   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   matrix_meta_reader dut (
      .clk(clk), .rst_n(rst_n), .read_request(read_request), .read_ready(read_ready),
      .matrix_id(matrix_id), .read_done(read_done), .meta_rows(meta_rows),
      .meta_cols(meta_cols), .meta_name(meta_name), .meta_valid(meta_valid),
      .meta_error(meta_error), .bram_rd_en(bram_rd_en), .bram_addr(bram_addr),
      .bram_dout(bram_dout));

   matrix_meta_reader #(.READ_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .read_request(req3), .read_ready(ready3),
      .matrix_id(id3), .read_done(done3), .meta_rows(rows3),
      .meta_cols(cols3), .meta_name(name3), .meta_valid(valid3),
      .meta_error(error3), .bram_rd_en(rd_en3), .bram_addr(addr3),
      .bram_dout(dout3));

   // BRAM models: latency 1 and latency 3
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bram_rd_en) bram_dout <= mem[bram_addr];
      if (rd_en3) p1_3 <= mem[addr3];
      p2_3  <= p1_3;
      dout3 <= p2_3;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic exp_err(input logic [31:0] w0);
      logic nz;
      nz = (w0[31:24] != 0) && (w0[23:16] != 0);
`ifdef MATRIX_META_CHECK_EN
      return nz && ((w0[31:24] > 8'd32) || (w0[23:16] > 8'd32) || (w0[15:0] != 0));
`else
      return 1'b0 & nz;
`endif
   endfunction

   typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
   typedef struct { int cyc; logic [7:0] r, c; logic [63:0] n; logic v, e; } exp_t;
   rd_t  addr_q[$];
   exp_t done_q[$];

   // Scoreboard: push on acceptance, pop on each read issue and each read_done
   always @(negedge clk) begin
      rd_t           ea;
      exp_t          ed;
      logic [AW-1:0] b;
      logic [31:0]   w0;
      if (!rst_n) begin
         addr_q.delete();
         done_q.delete();
      end else begin
         if (bram_rd_en) begin
            if (addr_q.size() == 0) check_val("unexpected_rd_en", 1, 0);
            else begin
               ea = addr_q.pop_front();
               check_val("rd_addr", bram_addr, ea.addr);
               check_val("rd_cycle", cyc, ea.cyc);
            end
         end
         if (read_done) begin
            if (done_q.size() == 0) check_val("unexpected_done", 1, 0);
            else begin
               ed = done_q.pop_front();
               check_val("done_cycle", cyc, ed.cyc);
               check_val("sb_rows", meta_rows, ed.r);
               check_val("sb_cols", meta_cols, ed.c);
               check_val("sb_name", meta_name, ed.n);
               check_val("sb_valid", meta_valid, ed.v);
               check_val("sb_error", meta_error, ed.e);
            end
         end
         if (read_request && read_ready) begin
            b  = AW'(int'(matrix_id) * BS);
            w0 = mem[b];
            for (int k = 0; k < 3; k++) begin
               ea.cyc  = cyc + 2 + k;
               ea.addr = b + AW'(k);
               addr_q.push_back(ea);
            end
            ed.cyc = cyc + 7;
            ed.r   = w0[31:24];
            ed.c   = w0[23:16];
            ed.n   = {mem[b + AW'(1)], mem[b + AW'(2)]};
            ed.v   = (w0[31:24] != 0) && (w0[23:16] != 0);
            ed.e   = exp_err(w0);
            done_q.push_back(ed);
         end
      end
   end

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (read_done) seen = 1;
      end
      if (!seen) check_val(tag, 0, 1);
   endtask

   task automatic do_read(input logic [2:0] id, input string tag);
      @(posedge clk); #1 read_request = 1'b1; matrix_id = id;
      @(posedge clk); #1 read_request = 1'b0;
      wait_done(tag);
   endtask

   int t1, acc3;
   bit seen3;

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = '0;
      mem[1152] = 32'h0400_0000; mem[1153] = "ROWS"; mem[1154] = "ONLY";
      mem[2304] = 32'h0305_0000; mem[2305] = "MATA"; mem[2306] = "0000";
      mem[3456] = 32'h0708_0000; mem[3457] = "BLK3"; mem[3458] = "____";
      mem[4608] = 32'h2105_0000; mem[4609] = "ABCD"; mem[4610] = "EFGH";
      mem[5760] = 32'h0202_0001; mem[5761] = "RSVD"; mem[5762] = "BITS";
      mem[6912] = 32'h2020_0000; mem[6913] = "EDGE"; mem[6914] = "3232";
      mem[8064] = 32'h0101_0000; mem[8065] = "SEVN"; mem[8066] = "7777";
      rst_n = 1'b0; read_request = 1'b0; matrix_id = 3'd0; req3 = 1'b0; id3 = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_rd_en", bram_rd_en, 0);
      check_val("rst_addr", bram_addr, 0);
      check_val("rst_done", read_done, 0);
      check_val("rst_rows", meta_rows, 0);
      check_val("rst_name", meta_name, 0);
      check_val("rst_valid", meta_valid, 0);
      check_val("rst_error", meta_error, 0);
      check_val("rst_ready", read_ready, 1);
      @(posedge clk); #1 rst_n = 1'b1;

      // block 2 basic read
      do_read(3'd2, "t1_timeout");
      check_val("t1_rows", meta_rows, 8'd3);
      check_val("t1_cols", meta_cols, 8'd5);
      check_val("t1_name", meta_name, 64'h4D41_5441_3030_3030);
      check_val("t1_valid", meta_valid, 1);
      check_val("t1_ready", read_ready, 1);

      // cleared block 0
      do_read(3'd0, "t2_timeout");
      check_val("t2_rows", meta_rows, 0);
      check_val("t2_name", meta_name, 0);
      check_val("t2_valid", meta_valid, 0);
      check_val("t2_error", meta_error, 0);

      // request while busy is ignored, id changes have no effect
      @(posedge clk); #1 read_request = 1'b1; matrix_id = 3'd3;
      @(posedge clk); #1 read_request = 1'b0; matrix_id = 3'd6;
      @(posedge clk); #1 read_request = 1'b1; matrix_id = 3'd5;
      @(negedge clk);
      check_val("t3_busy_ready", read_ready, 0);
      check_val("t3_hold_rows", meta_rows, 0);
      @(posedge clk); #1 read_request = 1'b0; matrix_id = 3'd4;
      wait_done("t3_timeout");
      check_val("t3_rows", meta_rows, 8'd7);
      check_val("t3_cols", meta_cols, 8'd8);

      // format-check corner blocks (scoreboard carries expectations)
      do_read(3'd5, "t5_timeout");
      do_read(3'd6, "t6_timeout");
      do_read(3'd4, "t4_timeout");

      // back-to-back from DONE: ids 1 then 7
      @(posedge clk); #1 read_request = 1'b1; matrix_id = 3'd1;
      @(posedge clk); #1 matrix_id = 3'd7;
      wait_done("b2b_first_timeout");
      check_val("b2b_first_valid", meta_valid, 0);
      t1 = cyc;
      @(posedge clk); #1 read_request = 1'b0;
      wait_done("b2b_second_timeout");
      check_val("b2b_gap", cyc - t1, 7);
      check_val("b2b_second_rows", meta_rows, 8'd1);

      // reset asserted while in WAIT
      @(posedge clk); #1 read_request = 1'b1; matrix_id = 3'd2;
      @(posedge clk); #1 read_request = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("wrst_rd_en", bram_rd_en, 0);
      check_val("wrst_done", read_done, 0);
      check_val("wrst_rows", meta_rows, 0);
      check_val("wrst_name", meta_name, 0);
      check_val("wrst_ready", read_ready, 1);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check_val("wrst_still_rows", meta_rows, 0);
      do_read(3'd2, "recover_timeout");
      check_val("recover_rows", meta_rows, 8'd3);

      // READ_LATENCY=3 instance: word0 = 0x2105_0000
      @(posedge clk); #1 req3 = 1'b1; id3 = 3'd4;
      @(posedge clk); #1 req3 = 1'b0;
      @(negedge clk); acc3 = cyc;
      seen3 = 0;
      for (int i = 0; i < 30 && !seen3; i++) begin
         if (done3) seen3 = 1;
         else @(negedge clk);
      end
      if (!seen3) check_val("l3_timeout", 0, 1);
      check_val("l3_latency", cyc - acc3, 8);
      check_val("l3_rows", rows3, 8'd33);
      check_val("l3_cols", cols3, 8'd5);
      check_val("l3_name", name3, 64'h4142_4344_4546_4748);
      check_val("l3_valid", valid3, 1);
`ifdef MATRIX_META_CHECK_EN
      check_val("l3_error", error3, 1);
`else
      check_val("l3_error", error3, 0);
`endif
      @(negedge clk);
      check_val("l3_done_pulse", done3, 0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
